// File: rtl/ctrl_decode.sv
// One-hot MIPS instruction decoder: combinational flags from the instruction word,
// plus a sticky register recording whether any unrecognised encoding was presented.
module ctrl_decode (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] I,
    output logic        lb,
    output logic        lbu,
    output logic        lh,
    output logic        lhu,
    output logic        lw,
    output logic        sb,
    output logic        sh,
    output logic        sw,
    output logic        R,
    output logic        add,
    output logic        addu,
    output logic        sub,
    output logic        subu,
    output logic        mult,
    output logic        multu,
    output logic        div,
    output logic        divu,
    output logic        slt,
    output logic        sltu,
    output logic        sll,
    output logic        srl,
    output logic        sra,
    output logic        sllv,
    output logic        srlv,
    output logic        srav,
    output logic        and_,
    output logic        or_,
    output logic        xor_,
    output logic        nor_,
    output logic        addi,
    output logic        addiu,
    output logic        andi,
    output logic        ori,
    output logic        xori,
    output logic        lui,
    output logic        slti,
    output logic        sltiu,
    output logic        beq,
    output logic        bne,
    output logic        blez,
    output logic        bgtz,
    output logic        bltz,
    output logic        bgez,
    output logic        j,
    output logic        jal,
    output logic        jalr,
    output logic        jr,
    output logic        mfhi,
    output logic        mflo,
    output logic        mthi,
    output logic        mtlo,
    output logic        unknown,
    output logic        unknown_seen
);

    localparam logic [5:0] OP_SPECIAL = 6'h00;
    localparam logic [5:0] OP_REGIMM  = 6'h01;

    logic [5:0] op;
    logic [4:0] rt;
    logic [5:0] funct;
    logic       special;
    logic       regimm;
    logic       any_flag;
    logic       unused_fields;

    assign op     = I[31:26];
    assign rt     = I[20:16];
    assign funct  = I[5:0];

    // rs, rd, shamt and immediate bits never affect the decode
    assign unused_fields = ^{I[25:21], I[15:6]};

    assign special = (op == OP_SPECIAL);
    assign regimm  = (op == OP_REGIMM);
    assign R       = special;

    assign lb    = (op == 6'h20);
    assign lh    = (op == 6'h21);
    assign lw    = (op == 6'h23);
    assign lbu   = (op == 6'h24);
    assign lhu   = (op == 6'h25);
    assign sb    = (op == 6'h28);
    assign sh    = (op == 6'h29);
    assign sw    = (op == 6'h2B);

    assign addi  = (op == 6'h08);
    assign addiu = (op == 6'h09);
    assign slti  = (op == 6'h0A);
    assign sltiu = (op == 6'h0B);
    assign andi  = (op == 6'h0C);
    assign ori   = (op == 6'h0D);
    assign xori  = (op == 6'h0E);
    assign lui   = (op == 6'h0F);

    assign j     = (op == 6'h02);
    assign jal   = (op == 6'h03);
    assign beq   = (op == 6'h04);
    assign bne   = (op == 6'h05);
    assign blez  = (op == 6'h06);
    assign bgtz  = (op == 6'h07);
    assign bltz  = regimm & (rt == 5'h00);
    assign bgez  = regimm & (rt == 5'h01);

    assign sll   = special & (funct == 6'h00);
    assign srl   = special & (funct == 6'h02);
    assign sra   = special & (funct == 6'h03);
    assign sllv  = special & (funct == 6'h04);
    assign srlv  = special & (funct == 6'h06);
    assign srav  = special & (funct == 6'h07);
    assign jr    = special & (funct == 6'h08);
    assign jalr  = special & (funct == 6'h09);
    assign mfhi  = special & (funct == 6'h10);
    assign mthi  = special & (funct == 6'h11);
    assign mflo  = special & (funct == 6'h12);
    assign mtlo  = special & (funct == 6'h13);
    assign mult  = special & (funct == 6'h18);
    assign multu = special & (funct == 6'h19);
    assign div   = special & (funct == 6'h1A);
    assign divu  = special & (funct == 6'h1B);
    assign add   = special & (funct == 6'h20);
    assign addu  = special & (funct == 6'h21);
    assign sub   = special & (funct == 6'h22);
    assign subu  = special & (funct == 6'h23);
    assign and_  = special & (funct == 6'h24);
    assign or_   = special & (funct == 6'h25);
    assign xor_  = special & (funct == 6'h26);
    assign nor_  = special & (funct == 6'h27);
    assign slt   = special & (funct == 6'h2A);
    assign sltu  = special & (funct == 6'h2B);

    // R is a class flag, not an instruction, so it does not count as a match
    assign any_flag = lb | lbu | lh | lhu | lw | sb | sh | sw |
                      add | addu | sub | subu | mult | multu | div | divu | slt | sltu |
                      sll | srl | sra | sllv | srlv | srav | and_ | or_ | xor_ | nor_ |
                      addi | addiu | andi | ori | xori | lui | slti | sltiu |
                      beq | bne | blez | bgtz | bltz | bgez | j | jal | jalr | jr |
                      mfhi | mflo | mthi | mtlo;

    assign unknown = ~any_flag;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            unknown_seen <= 1'b0;
        end else begin
            unknown_seen <= unknown_seen | unknown;
        end
    end

endmodule

// File: tb/tb_ctrl_decode.sv
// Scoreboard bench for ctrl_decode: an independent opcode/funct model queues expected
// flag vectors per applied instruction; the sticky status register is checked around reset.
module tb_ctrl_decode;

    logic        clk;
    logic        reset;
    logic [31:0] I;
    logic lb, lbu, lh, lhu, lw, sb, sh, sw, R;
    logic add, addu, sub, subu, mult, multu, div, divu, slt, sltu;
    logic sll, srl, sra, sllv, srlv, srav, and_, or_, xor_, nor_;
    logic addi, addiu, andi, ori, xori, lui, slti, sltiu;
    logic beq, bne, blez, bgtz, bltz, bgez, j, jal, jalr, jr;
    logic mfhi, mflo, mthi, mtlo, unknown, unknown_seen;

    int checks = 0;
    int errors = 0;
    logic [63:0] exp_q[$];

    ctrl_decode dut (
        .clk(clk), .reset(reset), .I(I),
        .lb(lb), .lbu(lbu), .lh(lh), .lhu(lhu), .lw(lw), .sb(sb), .sh(sh), .sw(sw),
        .R(R),
        .add(add), .addu(addu), .sub(sub), .subu(subu), .mult(mult), .multu(multu),
        .div(div), .divu(divu), .slt(slt), .sltu(sltu),
        .sll(sll), .srl(srl), .sra(sra), .sllv(sllv), .srlv(srlv), .srav(srav),
        .and_(and_), .or_(or_), .xor_(xor_), .nor_(nor_),
        .addi(addi), .addiu(addiu), .andi(andi), .ori(ori), .xori(xori), .lui(lui),
        .slti(slti), .sltiu(sltiu),
        .beq(beq), .bne(bne), .blez(blez), .bgtz(bgtz), .bltz(bltz), .bgez(bgez),
        .j(j), .jal(jal), .jalr(jalr), .jr(jr),
        .mfhi(mfhi), .mflo(mflo), .mthi(mthi), .mtlo(mtlo),
        .unknown(unknown), .unknown_seen(unknown_seen)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Bit 51 = unknown, bit 50 = R, bits 49..0 = flags with lb at 49 down to mtlo at 0.
    function automatic logic [63:0] observed();
        return {12'b0, unknown, R,
                lb, lbu, lh, lhu, lw, sb, sh, sw,
                add, addu, sub, subu, mult, multu, div, divu, slt, sltu,
                sll, srl, sra, sllv, srlv, srav, and_, or_, xor_, nor_,
                addi, addiu, andi, ori, xori, lui, slti, sltiu,
                beq, bne, blez, bgtz, bltz, bgez, j, jal, jalr, jr,
                mfhi, mflo, mthi, mtlo};
    endfunction

    // Position of the matching instruction in the flag list above, or -1.
    function automatic int model_pos(input logic [31:0] ins);
        logic [5:0] o, f;
        logic [4:0] t;
        o = ins[31:26];
        f = ins[5:0];
        t = ins[20:16];
        if (o == 6'h00) begin
            case (f)
                6'h00: return 18; 6'h02: return 19; 6'h03: return 20; 6'h04: return 21;
                6'h06: return 22; 6'h07: return 23; 6'h08: return 45; 6'h09: return 44;
                6'h10: return 46; 6'h11: return 48; 6'h12: return 47; 6'h13: return 49;
                6'h18: return 12; 6'h19: return 13; 6'h1A: return 14; 6'h1B: return 15;
                6'h20: return 8;  6'h21: return 9;  6'h22: return 10; 6'h23: return 11;
                6'h24: return 24; 6'h25: return 25; 6'h26: return 26; 6'h27: return 27;
                6'h2A: return 16; 6'h2B: return 17;
                default: return -1;
            endcase
        end
        if (o == 6'h01) begin
            if (t == 5'd0) return 40;
            if (t == 5'd1) return 41;
            return -1;
        end
        case (o)
            6'h20: return 0; 6'h24: return 1; 6'h21: return 2; 6'h25: return 3;
            6'h23: return 4; 6'h28: return 5; 6'h29: return 6; 6'h2B: return 7;
            6'h08: return 28; 6'h09: return 29; 6'h0C: return 30; 6'h0D: return 31;
            6'h0E: return 32; 6'h0F: return 33; 6'h0A: return 34; 6'h0B: return 35;
            6'h04: return 36; 6'h05: return 37; 6'h06: return 38; 6'h07: return 39;
            6'h02: return 42; 6'h03: return 43;
            default: return -1;
        endcase
    endfunction

    function automatic logic [63:0] model(input logic [31:0] ins);
        logic [63:0] v;
        int p;
        v = '0;
        p = model_pos(ins);
        if (p >= 0) v[49 - p] = 1'b1;
        else        v[51] = 1'b1;
        v[50] = (ins[31:26] == 6'h00);
        return v;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Drive an instruction, queue its expected decode, then compare once it has settled.
    task automatic apply(input string tag, input logic [31:0] ins);
        logic [63:0] e;
        logic [63:0] o;
        I = ins;
        exp_q.push_back(model(ins));
        #1;
        e = exp_q.pop_front();
        o = observed();
        check(tag, o, e);
        check({tag, "_onehot"}, 64'($countones(o[49:0])), 64'($countones(e[49:0])));
    endtask

    initial begin
        reset = 1'b1;
        I = 32'h0;

        // Sticky status register
        #2;
        check("seen_reset", 64'(unknown_seen), 64'd0);
        I = 32'hFC000000;
        @(posedge clk); #1;
        check("seen_held_in_reset", 64'(unknown_seen), 64'd0);
        check("unknown_fc", 64'(unknown), 64'd1);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("seen_before_edge", 64'(unknown_seen), 64'd0);
        @(posedge clk); #1;
        check("seen_set", 64'(unknown_seen), 64'd1);
        I = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        check("seen_sticky", 64'(unknown_seen), 64'd1);
        I = 32'hFC000000;
        @(negedge clk); #2;
        reset = 1'b1;
        #1;
        check("seen_async_clear", 64'(unknown_seen), 64'd0);
        @(posedge clk); #1;
        check("seen_clear_held", 64'(unknown_seen), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("seen_after_release", 64'(unknown_seen), 64'd0);
        @(posedge clk); #1;
        check("seen_reset_again", 64'(unknown_seen), 64'd1);

        // Directed decodes
        apply("add",     32'h00430820);
        check("add_flag", 64'(add), 64'd1);
        apply("addu",    32'h00430821);
        check("addu_flag", 64'(addu), 64'd1);
        apply("lw",      32'h8FA80004);
        check("lw_R", 64'(R), 64'd0);
        apply("sw",      32'hAFA80004);
        apply("lui",     32'h3C011234);
        apply("bltz",    32'h04200003);
        check("bltz_flag", 64'(bltz), 64'd1);
        apply("bgez",    32'h04210003);
        apply("regimm2", 32'h04220003);
        check("regimm2_unknown", 64'(unknown), 64'd1);
        apply("jal",     32'h0C000010);
        apply("jr",      32'h03E00008);
        apply("nop",     32'h00000000);
        check("nop_sll", 64'({R, sll, unknown}), 64'b110);
        apply("funct3f", 32'h0043083F);

        // Opcode sweep with random don't-care fields, funct sweep, REGIMM rt sweep
        for (int o = 0; o < 64; o++) begin
            apply("op_sweep", {6'(o), 26'($urandom)});
        end
        for (int f = 0; f < 64; f++) begin
            apply("funct_sweep", {6'h00, 20'($urandom), 6'(f)});
        end
        for (int t = 0; t < 32; t++) begin
            apply("rt_sweep", {6'h01, 5'($urandom), 5'(t), 16'($urandom)});
        end

        check("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ctrl_decode.md
# ctrl_decode

Combinational MIPS instruction decoder for the pipelined CPU. It takes a 32-bit instruction word and raises exactly one one-hot flag per recognised instruction, plus an R-type class flag. Pipeline stage registers (e.g. IF/ID) instantiate it to derive next-PC selection, forwarding and hazard controls. A small sticky status register records whether an unrecognised encoding was ever presented.

## Interface
- No parameters.
- clk  input  1  sole clock; only the sticky status register uses it.
- reset  input  1  asynchronous, active-high; clears the sticky status register.
- I  input  32  instruction word. Fields: op=I[31:26], rt=I[20:16], funct=I[5:0].
- lb, lbu, lh, lhu, lw, sb, sh, sw  output  1 each  load/store flags.
- R  output  1  R-type class (op==0).
- add, addu, sub, subu, mult, multu, div, divu, slt, sltu  output  1 each  R-type ALU/muldiv flags.
- sll, srl, sra, sllv, srlv, srav, and_, or_, xor_, nor_  output  1 each  R-type shift/logic flags.
- addi, addiu, andi, ori, xori, lui, slti, sltiu  output  1 each  immediate ALU flags.
- beq, bne, blez, bgtz, bltz, bgez, j, jal, jalr, jr  output  1 each  control-flow flags.
- mfhi, mflo, mthi, mtlo  output  1 each  HI/LO move flags.
- unknown  output  1  combinational; no instruction flag matches I.
- unknown_seen  output  1  registered sticky copy of unknown.

## Operation
- Opcode decode (op, hex): lb 20, lh 21, lw 23, lbu 24, lhu 25, sb 28, sh 29, sw 2B, addi 08, addiu 09, slti 0A, sltiu 0B, andi 0C, ori 0D, xori 0E, lui 0F, beq 04, bne 05, blez 06, bgtz 07, j 02, jal 03.
- op=01 (REGIMM): bltz when rt=00, bgez when rt=01; other rt values → unknown.
- op=00: R=1 always; funct decode (hex): sll 00, srl 02, sra 03, sllv 04, srlv 06, srav 07, jr 08, jalr 09, mfhi 10, mthi 11, mflo 12, mtlo 13, mult 18, multu 19, div 1A, divu 1B, add 20, addu 21, sub 22, subu 23, and_ 24, or_ 25, xor_ 26, nor_ 27, slt 2A, sltu 2B.
- Decode uses only op, funct and (for op=01) rt; rs/rd/shamt/immediate bits are ignored.
- At most one instruction flag is 1 for any I; R may accompany an R-type flag.
- I=0x00000000 (nop) decodes as R=1, sll=1, unknown=0.
- op=00 with unlisted funct: R=1, all instruction flags 0, unknown=1.
- unknown = NOR of all instruction flags (R excluded).
- I containing X/Z: outputs undefined; not required to be handled.

## Timing
- All flags and unknown are purely combinational from I, zero-cycle latency, no internal state.
- unknown_seen: on reset=1 goes to 0 immediately (asynchronous), holds 0 while reset asserted; otherwise at each rising clk edge becomes unknown_seen | unknown. Never clears except by reset.
- Reset value: unknown_seen=0; all other outputs depend only on I and are unaffected by reset.
- Reset asserted mid-cycle with unknown=1: unknown_seen drops to 0 at once and first re-sets at the first rising edge after reset deasserts.

## Test plan
- I=0x00430820 (add $1,$2,$3) → R=1, add=1, every other flag 0, unknown=0; change funct to 0x21 → addu=1 only.
- I=0x8FA80004 (lw) → lw=1, R=0; I=0xAFA80004 → sw=1; I=0x3C011234 → lui=1.
- I=0x04200003 → bltz=1; I=0x04210003 → bgez=1; I=0x04220003 → unknown=1, all flags 0.
- I=0x0C000010 → jal=1; I=0x03E00008 → R=1, jr=1; I=0x00000000 → R=1, sll=1.
- Sweep all 64 op and all 64 funct values → one-hot property holds; unknown=1 exactly for unlisted encodings.
- reset=1 then I=0xFC000000, reset=0 → unknown=1, unknown_seen=1 after next rising clk, stays 1 after I=0; assert reset between edges → unknown_seen=0 immediately.
